vga_frame_timer: RTL and testbench

- Upstream neighbour of the ping_pong frame-buffer stage: generates the hc/vc raster counters, hsync/vsync and video_on.
- Owns the write_to_two buffer-select, so the display and render buffers only swap at the first line of vertical blanking.
- The renderer requests a swap with a level handshake; the swap is acknowledged once per frame boundary.
- Defaults give 640x480@60 on a 25 MHz pixel clock.

---
 rtl/vga_frame_timer.sv | 114 +++++++++++
 tb/tb_vga_frame_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_timer.sv
// Raster timing generator for the ping_pong frame-buffer stage.
// Produces hc/vc counters, active-low syncs, video_on and frame_start, all
// registered and aligned with hc/vc. Also owns the write_to_two buffer select,
// which only flips at the first vertical-blanking line after a swap request.
module vga_frame_timer #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       swap_req,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       write_to_two,
    output logic       frame_start,
    output logic       swap_ack
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        ACK
    } swap_state_t;

    swap_state_t state, state_next;

    logic [9:0] hc_next;
    logic [9:0] vc_next;
    logic       swap_point_next;

    // Next raster position; decoded outputs are derived from it so that every
    // registered output lands in the same cycle as the hc/vc it describes.
    always_comb begin
        hc_next = hc + 10'd1;
        vc_next = vc;
        if (hc == H_LAST) begin
            hc_next = '0;
            if (vc == V_LAST) begin
                vc_next = '0;
            end else begin
                vc_next = vc + 10'd1;
            end
        end
        swap_point_next = (hc_next == '0) && (vc_next == V_VIS);
    end

    // Raster counters and registered sync/visibility decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc          <= '0;
            vc          <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            hsync       <= !((hc_next >= HS_START) && (hc_next < HS_END));
            vsync       <= !((vc_next >= VS_START) && (vc_next < VS_END));
            video_on    <= (hc_next < H_VIS) && (vc_next < V_VIS);
            frame_start <= (hc_next == '0) && (vc_next == '0);
        end
    end

    // Swap state register and buffer select.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            write_to_two <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == PENDING) && swap_point_next) begin
                write_to_two <= !write_to_two;
            end
        end
    end

    // Swap next-state: a request waits for the first blanking line; the ACK
    // cycle ignores swap_req so a held request becomes a new one afterwards.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (swap_req) state_next = PENDING;
            PENDING: if (swap_point_next) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign swap_ack = (state == ACK);

endmodule

// File: tb/tb_vga_frame_timer.sv
// Scoreboard bench for vga_frame_timer: a reduced-geometry instance exercises
// full frames and the swap handshake, a default-geometry instance checks the
// 640x480 line timing over the first lines after each reset.
module tb_vga_frame_timer;

    // Reduced geometry: 32 clocks per line, 20 lines per frame.
    localparam int HV = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VV = 12, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HV + HF + HSW + HB;
    localparam int VT = VV + VF + VSW + VB;
    localparam int FRAME = HT * VT;

    // Default geometry constants, written out from the 640x480@60 timing.
    localparam int D_HT = 800, D_VT = 525;

    typedef struct {
        int hc, vc;
        bit hs, vs, vo, fs, w2, ack;
        int dhc, dvc;
        bit dhs, dvs, dvo, dfs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       swap_req = 1'b0;

    logic [9:0] hc, vc;
    logic       hsync, vsync, video_on, write_to_two, frame_start, swap_ack;
    logic [9:0] d_hc, d_vc;
    logic       d_hs, d_vs, d_vo, d_w2, d_fs, d_ack;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // bench model state
    int cyc = 0;
    int m_hc = 0, m_vc = 0;
    bit m_w2 = 1'b0, m_pend = 1'b0, m_ack = 1'b0;

    // test-6 observation
    bit t6_on = 1'b0;
    int t6_acks = 0;
    int last_ack_cyc = -1;
    int mon_cyc = 0;

    always #5 clk = ~clk;

    vga_frame_timer #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .swap_req(swap_req),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .write_to_two(write_to_two), .frame_start(frame_start), .swap_ack(swap_ack)
    );

    vga_frame_timer dut_def (
        .clk(clk), .reset(reset), .swap_req(1'b0),
        .hc(d_hc), .vc(d_vc), .hsync(d_hs), .vsync(d_vs), .video_on(d_vo),
        .write_to_two(d_w2), .frame_start(d_fs), .swap_ack(d_ack)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, queue expectations.
    task automatic step(input logic r, input logic req);
        exp_t e;
        bit prev_ack;
        reset = r;
        swap_req = req;
        @(posedge clk);
        if (r) begin
            cyc = 0; m_w2 = 1'b0; m_pend = 1'b0; m_ack = 1'b0;
            m_hc = 0; m_vc = 0;
        end else begin
            prev_ack = m_ack;
            m_ack = 1'b0;
            cyc++;
            m_hc = cyc % HT;
            m_vc = (cyc / HT) % VT;
            if (m_pend) begin
                if (m_hc == 0 && m_vc == VV) begin
                    m_w2 = !m_w2; m_ack = 1'b1; m_pend = 1'b0;
                end
            end else if (!prev_ack && req) begin
                m_pend = 1'b1;
            end
        end
        e.hc  = m_hc;
        e.vc  = m_vc;
        e.hs  = !(m_hc >= 20 && m_hc <= 25);
        e.vs  = !(m_vc >= 14 && m_vc <= 15);
        e.vo  = (m_hc < 16) && (m_vc < 12);
        e.fs  = (m_hc == 0) && (m_vc == 0);
        e.w2  = m_w2;
        e.ack = m_ack;
        e.dhc = cyc % D_HT;
        e.dvc = (cyc / D_HT) % D_VT;
        e.dhs = !(e.dhc >= 656 && e.dhc <= 751);
        e.dvs = !(e.dvc >= 490 && e.dvc <= 491);
        e.dvo = (e.dhc < 640) && (e.dvc < 480);
        e.dfs = (e.dhc == 0) && (e.dvc == 0);
        sb.push_back(e);
        #1;
    endtask

    task automatic run_until(input int h, input int v, input logic req);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_hc == h && m_vc == v) return;
            step(1'b0, req);
        end
        check("run_until_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_to_ack(input string tag);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 1'b1);
            if (m_ack) break;
        end
        check({tag, "_ack"}, 32'(swap_ack), 32'd1);
    endtask

    // Scoreboard consumer: compare every queued cycle at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        mon_cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("hc", 32'(hc), 32'(e.hc));
            check("vc", 32'(vc), 32'(e.vc));
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("video_on", 32'(video_on), 32'(e.vo));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("write_to_two", 32'(write_to_two), 32'(e.w2));
            check("swap_ack", 32'(swap_ack), 32'(e.ack));
            check("def_hc", 32'(d_hc), 32'(e.dhc));
            check("def_vc", 32'(d_vc), 32'(e.dvc));
            check("def_hsync", 32'(d_hs), 32'(e.dhs));
            check("def_vsync", 32'(d_vs), 32'(e.dvs));
            check("def_video_on", 32'(d_vo), 32'(e.dvo));
            check("def_frame_start", 32'(d_fs), 32'(e.dfs));
            check("def_write_to_two", 32'(d_w2), 32'd0);
            check("def_swap_ack", 32'(d_ack), 32'd0);
        end
        if (t6_on && swap_ack === 1'b1) begin
            t6_acks++;
            if (last_ack_cyc >= 0) check("t6_ack_period", 32'(mon_cyc - last_ack_cyc), 32'(FRAME));
            check("t6_ack_hc", 32'(hc), 32'd0);
            check("t6_ack_vc", 32'(vc), 32'(VV));
            last_ack_cyc = mon_cyc;
        end
    end

    initial begin
        // Reset
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        check("rst_hc", 32'(hc), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd1);
        check("rst_vo", 32'(video_on), 32'd1);

        // 1: one full frame returns to (0,0) with no swap
        for (int i = 0; i < FRAME; i++) step(1'b0, 1'b0);
        check("t1_hc", 32'(hc), 32'd0);
        check("t1_vc", 32'(vc), 32'd0);
        check("t1_fs", 32'(frame_start), 32'd1);
        check("t1_w2", 32'(write_to_two), 32'd0);

        // 3: request mid-frame, dropped in the ACK cycle
        run_until(0, 8, 1'b0);
        run_to_ack("t3");
        check("t3_hc", 32'(hc), 32'd0);
        check("t3_vc", 32'(vc), 32'(VV));
        check("t3_w2", 32'(write_to_two), 32'd1);
        run_until(0, 0, 1'b0);
        run_until(1, VV, 1'b0);
        check("t3_no_retoggle", 32'(write_to_two), 32'd1);

        // 4: request first raised in the swap-point cycle itself
        run_until(0, VV, 1'b0);
        step(1'b0, 1'b1);
        check("t4_late_w2", 32'(write_to_two), 32'd1);
        run_to_ack("t4");
        check("t4_w2", 32'(write_to_two), 32'd0);
        step(1'b0, 1'b0);

        // 6: request held high for three frames
        run_until(0, 0, 1'b0);
        t6_on = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) step(1'b0, 1'b1);
        t6_on = 1'b0;
        check("t6_acks", 32'(t6_acks), 32'd3);
        check("t6_w2", 32'(write_to_two), 32'd1);

        // 5: reset mid-frame discards a pending swap
        run_until(0, 3, 1'b1);
        run_until(10, 6, 1'b1);
        step(1'b1, 1'b1);
        check("t5_hc", 32'(hc), 32'd0);
        check("t5_vc", 32'(vc), 32'd0);
        check("t5_w2", 32'(write_to_two), 32'd0);
        check("t5_hsync", 32'(hsync), 32'd1);
        check("t5_vsync", 32'(vsync), 32'd1);
        for (int i = 0; i < FRAME + 40; i++) step(1'b0, 1'b0);
        check("t5_no_toggle", 32'(write_to_two), 32'd0);

        // drain the scoreboard
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
